// File: rtl/vc_traffic_window_profiler_if.sv
// Observation bundle for num_links_p cache links: fwd/rev handshakes plus fwd packet coordinates.
// master drives the link-side view, slave is the passive profiler.
interface vc_traffic_window_profiler_if #(
    parameter int unsigned num_links_p    = 1,
    parameter int unsigned x_cord_width_p = 4,
    parameter int unsigned y_cord_width_p = 4
);
    logic [num_links_p-1:0]                     fwd_v;
    logic [num_links_p-1:0]                     fwd_ready_and_rev;
    logic [num_links_p-1:0][x_cord_width_p-1:0] fwd_src_x;
    logic [num_links_p-1:0][y_cord_width_p-1:0] fwd_src_y;
    logic [num_links_p-1:0][x_cord_width_p-1:0] fwd_x;
    logic [num_links_p-1:0][y_cord_width_p-1:0] fwd_y;
    logic [num_links_p-1:0]                     rev_v;
    logic [num_links_p-1:0]                     rev_ready_and_rev;

    modport master (
        output fwd_v, fwd_ready_and_rev, fwd_src_x, fwd_src_y, fwd_x, fwd_y,
        output rev_v, rev_ready_and_rev
    );

    modport slave (
        input fwd_v, fwd_ready_and_rev, fwd_src_x, fwd_src_y, fwd_x, fwd_y,
        input rev_v, rev_ready_and_rev
    );
endinterface

// File: rtl/vc_traffic_window_profiler.sv
// Per-link windowed traffic profiler: counts region fwd accepts, rev accepts and fwd stalls,
// snapshots each window and dumps the snapshot one link per cycle.
module vc_traffic_window_profiler #(
    parameter int unsigned link_addr_width_p = 28,
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned x_cord_width_p    = 4,
    parameter int unsigned y_cord_width_p    = 4,
    parameter int unsigned num_tiles_x_p     = 4,
    parameter int unsigned num_tiles_y_p     = 4,
    parameter int unsigned origin_x_p        = 0,
    parameter int unsigned origin_y_p        = 0,
    parameter int unsigned num_links_p       = 1,
    parameter int unsigned window_cycles_p   = 1024,
    parameter int unsigned ctr_width_p       = 16,
    parameter int unsigned event_trace_p     = 0
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    vc_traffic_window_profiler_if.slave         link_sif,
    input  logic [31:0]                         global_ctr_i,
    input  logic                                trace_en_i,
    output logic                                win_v_o,
    output logic                                win_partial_o,
    output logic [num_links_p*ctr_width_p-1:0]  win_fwd_o,
    output logic [num_links_p*ctr_width_p-1:0]  win_rev_o,
    output logic [num_links_p*ctr_width_p-1:0]  win_stall_o,
    output logic                                dump_busy_o
);
    localparam int unsigned WinW = (window_cycles_p > 1) ? $clog2(window_cycles_p) : 1;
    localparam int unsigned IdxW = (num_links_p > 1) ? $clog2(num_links_p) : 1;
    localparam logic [WinW-1:0] WinLast = WinW'(window_cycles_p - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(num_links_p - 1);
    localparam logic [ctr_width_p-1:0] CtrMax = '1;

    // A new window must not end before the previous dump has finished.
    if (window_cycles_p < num_links_p + 1) begin : g_bad_window
        $error("window_cycles_p must be >= num_links_p+1");
    end
    if (link_addr_width_p == 0 || data_width_p == 0 || num_links_p == 0) begin : g_bad_width
        $error("link widths and num_links_p must be nonzero");
    end

    typedef enum logic {StIdle, StCount} state_e;
    typedef enum logic {StDumpIdle, StDumpBusy} dump_state_e;
    typedef logic [num_links_p-1:0][ctr_width_p-1:0] ctr_arr_t;

    state_e          state_q, state_d;
    dump_state_e     dump_q, dump_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [WinW-1:0] win_ctr_q, win_ctr_d;
    logic            pend_q, pend_d;
    logic            win_v_q, win_v_d;
    logic            partial_q, partial_d;
    ctr_arr_t        fwd_q, fwd_d, rev_q, rev_d, stall_q, stall_d;
    ctr_arr_t        snap_fwd_q, snap_fwd_d, snap_rev_q, snap_rev_d, snap_stall_q, snap_stall_d;
    ctr_arr_t        fwd_inc, rev_inc, stall_inc;
    logic [num_links_p-1:0] fwd_ev, rev_ev, stall_ev;
    logic            count_en, cut_req, win_end, take_part;

    function automatic logic in_region(input logic [x_cord_width_p-1:0] x,
                                       input logic [y_cord_width_p-1:0] y);
        // Unsigned wrap turns the two-sided range test into one compare per axis.
        return ((32'(x) - origin_x_p) < num_tiles_x_p) && ((32'(y) - origin_y_p) < num_tiles_y_p);
    endfunction

    function automatic logic [ctr_width_p-1:0] sat_inc(input logic [ctr_width_p-1:0] c,
                                                       input logic ev);
        return (ev && c != CtrMax) ? c + 1'b1 : c;
    endfunction

    always_comb begin
        for (int l = 0; l < num_links_p; l++) begin
            fwd_ev[l]   = link_sif.fwd_v[l] & link_sif.fwd_ready_and_rev[l]
                        & in_region(link_sif.fwd_src_x[l], link_sif.fwd_src_y[l]);
            stall_ev[l] = link_sif.fwd_v[l] & ~link_sif.fwd_ready_and_rev[l];
            rev_ev[l]   = link_sif.rev_v[l] & link_sif.rev_ready_and_rev[l];
            fwd_inc[l]   = sat_inc(fwd_q[l], fwd_ev[l]);
            rev_inc[l]   = sat_inc(rev_q[l], rev_ev[l]);
            stall_inc[l] = sat_inc(stall_q[l], stall_ev[l]);
        end
    end

    assign count_en  = (state_q == StCount) && trace_en_i;
    assign cut_req   = (state_q == StCount) && !trace_en_i;
    assign win_end   = count_en && (win_ctr_q == WinLast);
    // A cut window waits for the running dump to drain before it is snapshotted.
    assign take_part = (cut_req || pend_q) && (dump_q == StDumpIdle);
    assign pend_d    = (cut_req || pend_q) && (dump_q != StDumpIdle);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            dump_q       <= StDumpIdle;
            idx_q        <= '0;
            win_ctr_q    <= '0;
            pend_q       <= 1'b0;
            win_v_q      <= 1'b0;
            partial_q    <= 1'b0;
            fwd_q        <= '0;
            rev_q        <= '0;
            stall_q      <= '0;
            snap_fwd_q   <= '0;
            snap_rev_q   <= '0;
            snap_stall_q <= '0;
        end else begin
            state_q      <= state_d;
            dump_q       <= dump_d;
            idx_q        <= idx_d;
            win_ctr_q    <= win_ctr_d;
            pend_q       <= pend_d;
            win_v_q      <= win_v_d;
            partial_q    <= partial_d;
            fwd_q        <= fwd_d;
            rev_q        <= rev_d;
            stall_q      <= stall_d;
            snap_fwd_q   <= snap_fwd_d;
            snap_rev_q   <= snap_rev_d;
            snap_stall_q <= snap_stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trace_en_i && !pend_q) state_d = StCount;
            StCount: if (!trace_en_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        dump_d = dump_q;
        idx_d  = idx_q;
        unique case (dump_q)
            StDumpIdle: begin
                if (win_end || take_part) begin
                    dump_d = StDumpBusy;
                    idx_d  = '0;
                end
            end
            StDumpBusy: begin
                if (idx_q == IdxLast) dump_d = StDumpIdle;
                else                  idx_d  = idx_q + 1'b1;
            end
            default: dump_d = StDumpIdle;
        endcase
    end

    always_comb begin
        fwd_d        = fwd_q;
        rev_d        = rev_q;
        stall_d      = stall_q;
        snap_fwd_d   = snap_fwd_q;
        snap_rev_d   = snap_rev_q;
        snap_stall_d = snap_stall_q;
        win_ctr_d    = win_ctr_q;
        win_v_d      = win_end || take_part;
        partial_d    = partial_q;
        if (win_end) begin
            snap_fwd_d   = fwd_inc;
            snap_rev_d   = rev_inc;
            snap_stall_d = stall_inc;
            fwd_d        = '0;
            rev_d        = '0;
            stall_d      = '0;
            win_ctr_d    = '0;
            partial_d    = 1'b0;
        end else if (count_en) begin
            fwd_d     = fwd_inc;
            rev_d     = rev_inc;
            stall_d   = stall_inc;
            win_ctr_d = win_ctr_q + 1'b1;
        end else if (take_part) begin
            snap_fwd_d   = fwd_q;
            snap_rev_d   = rev_q;
            snap_stall_d = stall_q;
            fwd_d        = '0;
            rev_d        = '0;
            stall_d      = '0;
            win_ctr_d    = '0;
            partial_d    = 1'b1;
        end
    end

    assign win_v_o       = win_v_q;
    assign win_partial_o = win_v_q & partial_q;
    assign win_fwd_o     = snap_fwd_q;
    assign win_rev_o     = snap_rev_q;
    assign win_stall_o   = snap_stall_q;
    assign dump_busy_o   = (dump_q == StDumpBusy);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (dump_q == StDumpBusy) begin
                $display("vc_win,%0d,%0d,%0d,%0d,%0d,%0d", global_ctr_i, idx_q,
                         snap_fwd_q[idx_q], snap_rev_q[idx_q], snap_stall_q[idx_q], partial_q);
            end
            for (int l = 0; l < num_links_p; l++) begin
                if (event_trace_p != 0 && count_en && fwd_ev[l]) begin
                    $display("vc_fwd,%0d,%0d,%0d,%0d,%0d,%0d", global_ctr_i, l,
                             link_sif.fwd_src_x[l], link_sif.fwd_src_y[l],
                             link_sif.fwd_x[l], link_sif.fwd_y[l]);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_vc_traffic_window_profiler.sv
// Directed bench: two profiler instances (8-cycle/2-link/8-bit and 24-cycle/1-link/3-bit)
// driven at negedge and sampled at the following negedge.
module tb_vc_traffic_window_profiler;
    localparam int unsigned CwA = 8;
    localparam int unsigned CwB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] gctr = '0;
    logic        ten_a, ten_b;
    logic        wv_a, wp_a, busy_a, wv_b, wp_b, busy_b;
    logic [2*CwA-1:0] wf_a, wr_a, ws_a;
    logic [CwB-1:0]   wf_b, wr_b, ws_b;
    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk) gctr <= gctr + 32'd1;

    vc_traffic_window_profiler_if #(.num_links_p(2), .x_cord_width_p(4), .y_cord_width_p(4)) if_a ();
    vc_traffic_window_profiler_if #(.num_links_p(1), .x_cord_width_p(4), .y_cord_width_p(4)) if_b ();

    vc_traffic_window_profiler #(
        .x_cord_width_p(4), .y_cord_width_p(4), .num_tiles_x_p(3), .num_tiles_y_p(2),
        .origin_x_p(2), .origin_y_p(1), .num_links_p(2), .window_cycles_p(8),
        .ctr_width_p(CwA), .event_trace_p(1)
    ) dut_a (
        .clk_i(clk), .reset_i(reset), .link_sif(if_a), .global_ctr_i(gctr),
        .trace_en_i(ten_a), .win_v_o(wv_a), .win_partial_o(wp_a), .win_fwd_o(wf_a),
        .win_rev_o(wr_a), .win_stall_o(ws_a), .dump_busy_o(busy_a)
    );

    vc_traffic_window_profiler #(
        .x_cord_width_p(4), .y_cord_width_p(4), .num_tiles_x_p(4), .num_tiles_y_p(4),
        .num_links_p(1), .window_cycles_p(24), .ctr_width_p(CwB), .event_trace_p(0)
    ) dut_b (
        .clk_i(clk), .reset_i(reset), .link_sif(if_b), .global_ctr_i(gctr),
        .trace_en_i(ten_b), .win_v_o(wv_b), .win_partial_o(wp_b), .win_fwd_o(wf_b),
        .win_rev_o(wr_b), .win_stall_o(ws_b), .dump_busy_o(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        ten_a = 1'b0;
        ten_b = 1'b0;
        if_a.fwd_v = '0; if_a.fwd_ready_and_rev = '0; if_a.rev_v = '0;
        if_a.rev_ready_and_rev = '0; if_a.fwd_src_x = '0; if_a.fwd_src_y = '0;
        if_a.fwd_x = '0; if_a.fwd_y = '0;
        if_b.fwd_v = '0; if_b.fwd_ready_and_rev = '0; if_b.rev_v = '0;
        if_b.rev_ready_and_rev = '0; if_b.fwd_src_x = '0; if_b.fwd_src_y = '0;
        if_b.fwd_x = '0; if_b.fwd_y = '0;
    endtask

    // Leaves the bench on the negedge where reset drops; caller drives the first vector there.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        int seen;
        logic [3:0] xs [8];
        logic [3:0] ys [8];
        logic [7:0] rv, rr;
        xs = '{4'd4, 4'd5, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd4};
        ys = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2};
        rv = 8'b1101_1011;  // bit i = cycle i
        rr = 8'b1000_1101;  // accepts at cycles 0, 3, 7

        reset = 1'b1;
        clear_inputs();
        cyc(3);
        check_eq("rst_win_v", 32'(wv_a), 0);
        check_eq("rst_fwd", 32'(wf_a), 0);
        check_eq("rst_busy", 32'(busy_a), 0);
        reset = 1'b0;

        // Full window, link0 accepting in-region every cycle.
        ten_a = 1'b1;
        if_a.fwd_v[0] = 1'b1; if_a.fwd_ready_and_rev[0] = 1'b1;
        if_a.fwd_src_x[0] = 4'd2; if_a.fwd_src_y[0] = 4'd1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            seen += int'(wv_a);
        end
        check_eq("t1_no_early_win", 32'(seen), 0);
        cyc(1);
        check_eq("t1_win_v", 32'(wv_a), 1);
        check_eq("t1_partial", 32'(wp_a), 0);
        check_eq("t1_fwd0", 32'(wf_a[7:0]), 8);
        check_eq("t1_fwd1", 32'(wf_a[15:8]), 0);
        check_eq("t1_stall0", 32'(ws_a[7:0]), 0);
        check_eq("t1_busy", 32'(busy_a), 1);
        // Cut the next window while the dump is still running: deferred empty partial.
        ten_a = 1'b0;
        cyc(1);
        check_eq("t1_busy_idx1", 32'(busy_a), 1);
        check_eq("t1_no_win_busy", 32'(wv_a), 0);
        cyc(1);
        check_eq("t1_dump_done", 32'(busy_a), 0);
        check_eq("t1_defer_wait", 32'(wv_a), 0);
        cyc(1);
        check_eq("t1b_win_v", 32'(wv_a), 1);
        check_eq("t1b_partial", 32'(wp_a), 1);
        check_eq("t1b_fwd0_zero", 32'(wf_a[7:0]), 0);

        // Reset in the middle of the second window.
        do_reset();
        ten_a = 1'b1;
        if_a.fwd_v[0] = 1'b1; if_a.fwd_ready_and_rev[0] = 1'b1;
        if_a.fwd_src_x[0] = 4'd3; if_a.fwd_src_y[0] = 4'd2;
        cyc(9);
        check_eq("t5_pre_fwd0", 32'(wf_a[7:0]), 8);
        cyc(5);
        reset = 1'b1;
        cyc(1);
        check_eq("t5_rst_win_v", 32'(wv_a), 0);
        check_eq("t5_rst_fwd", 32'(wf_a), 0);
        check_eq("t5_rst_rev", 32'(wr_a), 0);
        check_eq("t5_rst_stall", 32'(ws_a), 0);
        check_eq("t5_rst_busy", 32'(busy_a), 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            seen += int'(wv_a);
        end
        check_eq("t5_no_aborted_win", 32'(seen), 0);
        cyc(1);
        check_eq("t5_win_v", 32'(wv_a), 1);
        check_eq("t5_fwd0_fresh", 32'(wf_a[7:0]), 8);

        // Stalls on link1, then one out-of-region accept.
        do_reset();
        ten_a = 1'b1;
        if_a.fwd_v[1] = 1'b1; if_a.fwd_src_x[1] = 4'd2; if_a.fwd_src_y[1] = 4'd1;
        cyc(6);
        if_a.fwd_ready_and_rev[1] = 1'b1; if_a.fwd_src_x[1] = 4'd5;
        cyc(1);
        if_a.fwd_v[1] = 1'b0;
        cyc(2);
        check_eq("t2_win_v", 32'(wv_a), 1);
        check_eq("t2_stall1", 32'(ws_a[15:8]), 5);
        check_eq("t2_fwd1", 32'(wf_a[15:8]), 0);
        check_eq("t2_stall0", 32'(ws_a[7:0]), 0);

        // Region edges on link0 plus rev handshakes on link1.
        do_reset();
        ten_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if_a.fwd_v[0] = 1'b1; if_a.fwd_ready_and_rev[0] = 1'b1;
            if_a.fwd_src_x[0] = xs[i]; if_a.fwd_src_y[0] = ys[i];
            if_a.fwd_x[0] = 4'd7; if_a.fwd_y[0] = 4'd0;
            if_a.rev_v[1] = rv[i]; if_a.rev_ready_and_rev[1] = rr[i];
        end
        cyc(1);
        check_eq("t6_win_v", 32'(wv_a), 1);
        check_eq("t6_region_fwd0", 32'(wf_a[7:0]), 4);
        check_eq("t6_rev1", 32'(wr_a[15:8]), 3);
        check_eq("t6_rev0", 32'(wr_a[7:0]), 0);

        // Early trace_en drop: partial window with two rev accepts.
        do_reset();
        ten_a = 1'b1;
        cyc(1);
        if_a.rev_v[0] = 1'b1; if_a.rev_ready_and_rev[0] = 1'b1;
        cyc(1);
        if_a.rev_ready_and_rev[0] = 1'b0;
        cyc(1);
        if_a.rev_ready_and_rev[0] = 1'b1;
        cyc(1);
        ten_a = 1'b0;
        if_a.rev_v[0] = 1'b0;
        cyc(1);
        check_eq("t4_win_v", 32'(wv_a), 1);
        check_eq("t4_partial", 32'(wp_a), 1);
        check_eq("t4_rev0", 32'(wr_a[7:0]), 2);
        check_eq("t4_rev1", 32'(wr_a[15:8]), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            seen += int'(wv_a);
        end
        check_eq("t4_idle_no_win", 32'(seen), 0);
        check_eq("t4_snap_stable", 32'(wr_a[7:0]), 2);

        // Saturation on the 3-bit instance.
        do_reset();
        ten_b = 1'b1;
        if_b.fwd_v[0] = 1'b1; if_b.fwd_ready_and_rev[0] = 1'b1;
        if_b.rev_v[0] = 1'b1; if_b.rev_ready_and_rev[0] = 1'b1;
        cyc(21);
        if_b.fwd_v[0] = 1'b0; if_b.rev_v[0] = 1'b0;
        cyc(4);
        check_eq("t3_win_v", 32'(wv_b), 1);
        check_eq("t3_partial", 32'(wp_b), 0);
        check_eq("t3_fwd_sat", 32'(wf_b), 7);
        check_eq("t3_rev_sat", 32'(wr_b), 7);
        check_eq("t3_stall", 32'(ws_b), 0);
        check_eq("t3_busy", 32'(busy_b), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
